// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply unit: op encoding, FSM states, sizing helpers.
// Latency: none (declarations only).
// Backpressure: none.
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    // Counter width that can hold 0..n-1; never narrower than one bit.
    function automatic int hilo_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int HILO_CNT_W = hilo_cnt_w(HILO_WIDTH);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MSUB  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FINAL = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_shift_add_core.sv
// Unsigned iterative shift-add multiplier: one multiplier bit per step_i cycle.
// Latency: CYCLES steps (fewer with HILO_EARLY_TERM_EN once the multiplier empties).
// Backpressure: none; the owner sequences load_i/step_i. Optional macro: HILO_EARLY_TERM_EN.
module hilo_shift_add_core
    import hilo_pkg::*;
#(
    parameter int WIDTH  = HILO_WIDTH,
    parameter int CYCLES = WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic                 last_o
);
    localparam int CNT_W = hilo_cnt_w(CYCLES);

    // The multiplicand walks left instead of the product walking right, so the
    // accumulated product is already aligned the moment the multiplier empties.
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Next-state of one iteration and end-of-multiply detect.
    always_comb begin
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef HILO_EARLY_TERM_EN
        last_o   = (cnt_q == CNT_W'(CYCLES - 1)) || (mplier_d == '0);
`else
        last_o   = (cnt_q == CNT_W'(CYCLES - 1));
`endif
    end

    // Datapath registers: load clears the product and counter, step iterates.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/hilo_mul_unit.sv
// HI/LO owner: mult/multu/madd/msub via iterative core, mthi/mtlo, mfhi/mflo read port.
// Latency: mthi/mtlo next edge; multiplies Busy for CYCLES+1 cycles, result with Done after.
// Backpressure: Start ignored while Busy; Stall = RdReq & Busy. Optional macro: HILO_EARLY_TERM_EN.
module hilo_mul_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH  = HILO_WIDTH,
    parameter int CYCLES = WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             RdReq,
    input  logic             RdSel,
    output logic [WIDTH-1:0] RdData,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    hilo_state_e        state_q;
    hilo_op_e           op_q;
    logic               sign_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               mul_start;
    logic               signed_op;
    logic [WIDTH-1:0]   mcand_abs, mplier_abs;
    logic [2*WIDTH-1:0] prod, prod_signed, acc_d;
    logic               core_last;

    // Issue decode and operand magnitude for signed ops.
    always_comb begin
        mul_start  = Start && (state_q == ST_IDLE) &&
                     ((Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_MADD) || (Op == OP_MSUB));
        signed_op  = (Op != OP_MULTU);
        mcand_abs  = (signed_op && A[WIDTH-1]) ? -A : A;
        mplier_abs = (signed_op && B[WIDTH-1]) ? -B : B;
    end

    hilo_shift_add_core #(
        .WIDTH  (WIDTH),
        .CYCLES (CYCLES)
    ) u_core (
        .clk_i    (Clk),
        .rst_n_i  (Reset),
        .load_i   (mul_start),
        .step_i   (state_q == ST_CALC),
        .mcand_i  (mcand_abs),
        .mplier_i (mplier_abs),
        .prod_o   (prod),
        .last_o   (core_last)
    );

    // Apply the sign and fold into {HI,LO} according to the latched op; modulo 2^(2*WIDTH).
    always_comb begin
        prod_signed = sign_q ? -prod : prod;
        case (op_q)
            OP_MADD: acc_d = {hi_q, lo_q} + prod_signed;
            OP_MSUB: acc_d = {hi_q, lo_q} - prod_signed;
            default: acc_d = prod_signed;
        endcase
    end

    // Control FSM plus the architectural HI/LO registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                op_q    <= hilo_op_e'(Op);
                                sign_q  <= (Op != OP_MULTU) && (A[WIDTH-1] ^ B[WIDTH-1]);
                                busy_q  <= 1'b1;
                                state_q <= ST_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (core_last) begin
                        state_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    {hi_q, lo_q} <= acc_d;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Stall  = RdReq & busy_q;
    assign RdData = RdSel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Randomized + directed bench for hilo_mul_unit against a 64-bit arithmetic reference.
// Latency: checks exact Busy length and the Done cycle of every multiply.
// Backpressure: checks Stall/RdData during Busy and that Start is ignored while Busy.
module tb_hilo_mul_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset, Start, RdReq, RdSel;
    logic [2:0]   Op;
    logic [W-1:0] A, B;
    logic [W-1:0] RdData, Hi, Lo;
    logic         Stall, Busy, Done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    hilo_mul_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .RdReq(RdReq), .RdSel(RdSel), .RdData(RdData), .Stall(Stall),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact 64-bit product by plain integer arithmetic.
    function automatic logic [63:0] model_prod(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (op == 3'd1) return {32'd0, a} * {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Expected number of Busy cycles for a multiply.
    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
`ifdef HILO_EARLY_TERM_EN
        logic [31:0] m;
        int k;
        m = (op != 3'd1 && b[31]) ? -b : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return k + 2;
`else
        return (op == op) ? 33 : 33;
`endif
    endfunction

    // Issue one op; for multiplies follow it through Busy and the Done cycle.
    // inject_at: busy cycle at which a Start(MTHI,9) is attempted (-1 none).
    // abort_at: busy cycle at which Reset is pulled low (-1 none).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input int abort_at);
        logic [31:0] hi0, lo0;
        logic [63:0] acc, p;
        int          busy_n;
        hi0 = hi_m;
        lo0 = lo_m;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b; RdReq = 1'b0;
        @(negedge Clk);
        Start = 1'b0; A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 7));
        if (op > 3'd3) begin
            if (op == 3'd4) hi_m = a;
            else if (op == 3'd5) lo_m = a;
            chk("nomul_busy", 64'(Busy), 64'(0));
            chk("nomul_done", 64'(Done), 64'(0));
            chk("nomul_hi", 64'(Hi), 64'(hi_m));
            chk("nomul_lo", 64'(Lo), 64'(lo_m));
            return;
        end
        p   = model_prod(op, a, b);
        acc = {hi0, lo0};
        if (op == 3'd2) acc = acc + p;
        else if (op == 3'd3) acc = acc - p;
        else acc = p;
        busy_n = 0;
        while (Busy && busy_n < 100) begin
            busy_n++;
            RdReq = 1'($urandom);
            RdSel = 1'($urandom);
            #1;
            chk("busy_done", 64'(Done), 64'(0));
            chk("busy_stall", 64'(Stall), 64'(RdReq));
            chk("busy_rddata", 64'(RdData), 64'(RdSel ? hi0 : lo0));
            chk("busy_hilo", {Hi, Lo}, {hi0, lo0});
            if (busy_n == inject_at) begin
                Start = 1'b1; Op = 3'd4; A = 32'd9;
            end else begin
                Start = 1'b0;
            end
            if (busy_n == abort_at) begin
                Reset = 1'b0;
                @(negedge Clk);
                Reset = 1'b1;
                hi_m = '0;
                lo_m = '0;
                chk("rst_hi", 64'(Hi), 64'(0));
                chk("rst_lo", 64'(Lo), 64'(0));
                chk("rst_busy", 64'(Busy), 64'(0));
                chk("rst_done", 64'(Done), 64'(0));
                @(negedge Clk);
                chk("rst_done2", 64'(Done), 64'(0));
                chk("rst_busy2", 64'(Busy), 64'(0));
                chk("rst_hilo2", {Hi, Lo}, 64'(0));
                return;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        chk("busy_len", 64'(busy_n), 64'(exp_busy(op, b)));
        hi_m = acc[63:32];
        lo_m = acc[31:0];
        RdReq = 1'b1;
        RdSel = 1'b0;
        #1;
        chk("done_pulse", 64'(Done), 64'(1));
        chk("done_stall", 64'(Stall), 64'(0));
        chk("done_rddata", 64'(RdData), 64'(lo_m));
        chk("done_hilo", {Hi, Lo}, {hi_m, lo_m});
        RdReq = 1'b0;
        @(negedge Clk);
        chk("done_clear", 64'(Done), 64'(0));
    endtask

    task automatic do_bad_op(input logic [2:0] op);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = $urandom; B = $urandom;
        @(negedge Clk);
        Start = 1'b0;
        chk("badop_busy", 64'(Busy), 64'(0));
        chk("badop_hilo", {Hi, Lo}, {hi_m, lo_m});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0; RdReq = 1'b1; RdSel = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reset_hi", 64'(Hi), 64'(0));
        chk("reset_lo", 64'(Lo), 64'(0));
        chk("reset_busy", 64'(Busy), 64'(0));
        chk("reset_done", 64'(Done), 64'(0));
        chk("reset_stall", 64'(Stall), 64'(0));
        Reset = 1'b1;
        RdReq = 1'b0;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, -1, -1);
        chk("mult_neg3x5", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        chk("multu_max", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        chk("mult_m1m1", {Hi, Lo}, 64'h0000_0000_0000_0001);
        do_op(3'd5, 32'd10, 32'd0, -1, -1);
        do_op(3'd2, 32'd2, 32'd3, -1, -1);
        chk("madd_16", {Hi, Lo}, 64'h0000_0000_0000_0010);
        do_op(3'd3, 32'd4, 32'd5, -1, -1);
        chk("msub_neg4", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFC);
        do_op(3'd0, 32'd7, 32'd6, 5, -1);
        chk("mult_42_inject", {Hi, Lo}, 64'd42);
        do_op(3'd4, 32'h55, 32'd0, -1, -1);
        do_op(3'd0, 32'd3, 32'd3, -1, 10);
        do_op(3'd0, 32'd2, 32'd2, -1, -1);
        chk("mult_after_rst", {Hi, Lo}, 64'd4);
        do_op(3'd1, 32'h1234, 32'd1, -1, -1);
        chk("multu_b1", 64'(Lo), 64'h1234);
        do_op(3'd1, 32'h1234, 32'd0, -1, -1);
        chk("multu_b0", {Hi, Lo}, 64'd0);
        do_bad_op(3'd6);
        do_bad_op(3'd7);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            if (sel > 5) do_bad_op(3'(sel));
            else do_op(3'(sel), pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0) ? 3 : -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
